dual_pipe_merge_arbiter: RTL and testbench
==========================================

# dual_pipe_merge_arbiter

Merges the tail outputs of the two counter-fed pipelines into a single consumer port. The consumer accepts one item per cycle, and the design has no output buffering. The block arbitrates between the lanes round-robin and drives the shared `global_stall` consumed by the producer FSM and both pipelines. When both lanes present an item in the same cycle, or the consumer is not ready, the whole system freezes until every pending item has drained. It also keeps small performance counters for stall and grant activity.

## Interface
Parameters:
- `DATA_W`, 32: width of the pipeline data words.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid_1` input 1: lane 1 tail item valid.
- `in_flush_1` input 1: lane 1 tail item is a flush marker.
- `in_data_1` input `DATA_W`: lane 1 tail data.
- `in_valid_2` input 1: lane 2 tail item valid.
- `in_flush_2` input 1: lane 2 tail item is a flush marker.
- `in_data_2` input `DATA_W`: lane 2 tail data.
- `out_ready` input 1: consumer can accept an item this cycle.
- `out_valid` output 1: an item is presented to the consumer.
- `out_data` output `DATA_W`: data of the granted lane.
- `out_src` output 1: granted lane (0 = lane 1, 1 = lane 2).
- `global_stall` output 1: freeze for the producer and both pipelines.
- `stall_cycles` output `CNT_W`: saturating count of cycles with `global_stall`=1.
- `grant_count_1` output `CNT_W`: wrapping count of lane 1 transfers.
- `grant_count_2` output `CNT_W`: wrapping count of lane 2 transfers.

## Operation
State registers:
- `served_1`, `served_2`: lane already transferred during the current stall episode.
- `last_src`: last granted lane.
- The three counters.

Request and grant rules:
- `pend_x` = `in_valid_x` & ~`in_flush_x` & ~`served_x`.
- Flush markers are never requests and are dropped silently. If `in_flush_x` and `in_valid_x` are both 1, flush wins.
- Grant when exactly one lane is pending: that lane.
- Grant when both lanes are pending: the lane ≠ `last_src` (round-robin).
- `out_valid` = `pend_1` | `pend_2`. `out_data` and `out_src` follow the granted lane.
- When `out_valid`=0, `out_data` and `out_src` show lane 1 and their values are don't-care.
- Transfer occurs when `out_valid` & `out_ready`.

Stall rule:
- `global_stall` = 1 when at least one pending lane is not transferred this cycle.
- Case A: both lanes pending. A transfer drains only one of them, so `global_stall`=1.
- Case B: any lane pending and `out_ready`=0, so `global_stall`=1.

Next-state rules:
- If `global_stall`=1: `served_x` |= (transfer from lane x).
- If `global_stall`=0: `served_1` and `served_2` clear to 0.
- On a transfer: `last_src` ← granted lane, and the matching `grant_count_x` increments, wrapping.
- `stall_cycles` increments every cycle `global_stall`=1 and saturates at all-ones.

Upstream behaviour relied on: during a stall, the pipelines hold their tail outputs stable, so `served` correctly masks items that have already been transferred.

## Timing
- Data path is combinational, zero-cycle latency: input to `out_data`/`out_valid`/`global_stall` in the same cycle. There is no buffer.
- State and counters update on the rising edge of `clk`.

Reset (asynchronous, `reset_n`=0):
- `served_1`, `served_2` = 0.
- `last_src` = 1, so lane 1 wins the first tie.
- All counters = 0.
- With the upstream held in reset (inputs invalid), `out_valid`=0 and `global_stall`=0.

Boundary cases:
- Reset asserted mid-stall: `served` clears immediately. After release, any held items re-arbitrate from a lane 1 tie priority.
- Two-lane tie with `out_ready`=1: stall lasts exactly 1 cycle and items go out on back-to-back cycles.
- Two-lane tie with `out_ready` low for N cycles: stall lasts N+1 cycles in total.
- `in_valid_x` dropping while `served_x`=1 is a protocol violation upstream and requires no special handling.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with idle inputs, then release. Expect all counters 0, `out_valid`=0, `global_stall`=0.
- Single lane: `in_valid_1`=1, `in_data_1`=0x02, `out_ready`=1. Expect `out_valid`=1, `out_data`=0x02, `out_src`=0, `global_stall`=0. `grant_count_1`=1 next cycle.
- Tie after reset: both lanes valid (data 0x02 and 0x03), `out_ready`=1.
  - Cycle 0: expect `out_src`=0, data 0x02, `global_stall`=1.
  - Cycle 1, inputs held: expect `out_src`=1, data 0x03, `global_stall`=0.
  - After: `stall_cycles`=1.
- Backpressure: lane 2 valid with data 0x05, `out_ready`=0 for 3 cycles, then 1. Expect `global_stall`=1 for 3 cycles with 0x05 held, transfer on cycle 4, and `stall_cycles`=3.
- Flush drop: `in_flush_1`=1, `in_valid_1`=0, `in_valid_2`=1. Expect only lane 2 granted, no stall, `grant_count_1` unchanged.
- Saturation and reset mid-stall:
  - With `CNT_W`=4, `out_ready`=0 for 20 cycles: expect `stall_cycles`=15.
  - Assert `reset_n` during that stall: expect counters 0 and `served` cleared.

Source files
------------

// File: rtl/dual_pipe_merge_arbiter.sv
// Round-robin merge of two pipeline tails onto one unbuffered consumer port.
// Drives the shared freeze (global_stall) and keeps stall/grant performance counters.
module dual_pipe_merge_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_1,
    input  logic              in_flush_1,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_valid_2,
    input  logic              in_flush_2,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              global_stall,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  grant_count_1,
    output logic [CNT_W-1:0]  grant_count_2
);

    logic             served_1_q, served_1_d;
    logic             served_2_q, served_2_d;
    logic             last_src_q, last_src_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] grant_count_1_q, grant_count_1_d;
    logic [CNT_W-1:0] grant_count_2_q, grant_count_2_d;

    logic pend_1, pend_2, grant_2, xfer;

    always_comb begin
        // A flush marker is never a request, even when valid is also high.
        pend_1  = in_valid_1 & ~in_flush_1 & ~served_1_q;
        pend_2  = in_valid_2 & ~in_flush_2 & ~served_2_q;
        grant_2 = pend_2 & (~pend_1 | ~last_src_q);

        out_valid    = pend_1 | pend_2;
        out_src      = grant_2;
        out_data     = grant_2 ? in_data_2 : in_data_1;
        xfer         = out_valid & out_ready;
        global_stall = (pend_1 & pend_2) | (out_valid & ~out_ready);

        served_1_d      = 1'b0;
        served_2_d      = 1'b0;
        last_src_d      = last_src_q;
        stall_cycles_d  = stall_cycles_q;
        grant_count_1_d = grant_count_1_q;
        grant_count_2_d = grant_count_2_q;

        // Served flags only live for the duration of one stall episode.
        if (global_stall) begin
            served_1_d = served_1_q | (xfer & ~grant_2);
            served_2_d = served_2_q | (xfer & grant_2);
            if (stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + 1'b1;
            end
        end

        if (xfer) begin
            last_src_d = grant_2;
            if (grant_2) begin
                grant_count_2_d = grant_count_2_q + 1'b1;
            end else begin
                grant_count_1_d = grant_count_1_q + 1'b1;
            end
        end
    end

    // last_src resets to lane 2 so lane 1 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served_1_q      <= 1'b0;
            served_2_q      <= 1'b0;
            last_src_q      <= 1'b1;
            stall_cycles_q  <= '0;
            grant_count_1_q <= '0;
            grant_count_2_q <= '0;
        end else begin
            served_1_q      <= served_1_d;
            served_2_q      <= served_2_d;
            last_src_q      <= last_src_d;
            stall_cycles_q  <= stall_cycles_d;
            grant_count_1_q <= grant_count_1_d;
            grant_count_2_q <= grant_count_2_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign grant_count_1 = grant_count_1_q;
    assign grant_count_2 = grant_count_2_q;

endmodule

// File: tb/tb_dual_pipe_merge_arbiter.sv
// Scoreboard bench for dual_pipe_merge_arbiter: stimulus queues expected presented items,
// a negedge monitor pops and compares them; counters are checked directly by the stimulus.
module tb_dual_pipe_merge_arbiter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid_1, in_flush_1, in_valid_2, in_flush_2, out_ready;
    logic [DATA_W-1:0] in_data_1, in_data_2;
    logic              out_valid, out_src, global_stall;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cycles, grant_count_1, grant_count_2;

    dual_pipe_merge_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid_1    (in_valid_1),
        .in_flush_1    (in_flush_1),
        .in_data_1     (in_data_1),
        .in_valid_2    (in_valid_2),
        .in_flush_2    (in_flush_2),
        .in_data_2     (in_data_2),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .global_stall  (global_stall),
        .stall_cycles  (stall_cycles),
        .grant_count_1 (grant_count_1),
        .grant_count_2 (grant_count_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              src;
        logic              stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_item(input logic [DATA_W-1:0] d, input logic s, input logic st);
        exp_t e;
        e.data  = d;
        e.src   = s;
        e.stall = st;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic f1, input logic [DATA_W-1:0] d1,
                         input logic v2, input logic f2, input logic [DATA_W-1:0] d2,
                         input logic rdy);
        in_valid_1 = v1; in_flush_1 = f1; in_data_1 = d1;
        in_valid_2 = v2; in_flush_2 = f2; in_data_2 = d2;
        out_ready  = rdy;
    endtask

    // Monitor: every cycle the DUT presents an item out of reset, it must match the next expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_item: got data 0x%0h src %0d, none expected at %0t",
                         out_data, out_src, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_src", {31'd0, out_src}, {31'd0, e.src});
                chk("global_stall", {31'd0, global_stall}, {31'd0, e.stall});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step();
        reset_n = 1'b1;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_global_stall", {31'd0, global_stall}, 0);
        chk("reset_stall_cycles", {28'd0, stall_cycles}, 0);
        chk("reset_grant_count_1", {28'd0, grant_count_1}, 0);
        chk("reset_grant_count_2", {28'd0, grant_count_2}, 0);

        // Tie after reset: lane 1 first with a one-cycle stall, lane 2 next cycle.
        step();
        drive(1, 0, 32'h02, 1, 0, 32'h03, 1);
        expect_item(32'h02, 0, 1);
        expect_item(32'h03, 1, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("tie_stall_cycles", {28'd0, stall_cycles}, 1);
        chk("tie_grant_count_1", {28'd0, grant_count_1}, 1);
        chk("tie_grant_count_2", {28'd0, grant_count_2}, 1);

        // Single lane 1 item.
        drive(1, 0, 32'h02, 0, 0, 0, 1);
        expect_item(32'h02, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("single_grant_count_1", {28'd0, grant_count_1}, 2);

        // Backpressure on lane 2 for 3 cycles, then accepted.
        drive(0, 0, 0, 1, 0, 32'h05, 0);
        for (int i = 0; i < 3; i++) begin
            expect_item(32'h05, 1, 1);
            step();
        end
        out_ready = 1'b1;
        expect_item(32'h05, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("bp_stall_cycles", {28'd0, stall_cycles}, 4);
        chk("bp_grant_count_2", {28'd0, grant_count_2}, 2);

        // Flush markers are dropped: flush alone, then flush together with valid.
        drive(0, 1, 32'h09, 1, 0, 32'h07, 1);
        expect_item(32'h07, 1, 0);
        step();
        drive(1, 1, 32'h09, 1, 0, 32'h08, 1);
        expect_item(32'h08, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("flush_grant_count_1", {28'd0, grant_count_1}, 2);
        chk("flush_grant_count_2", {28'd0, grant_count_2}, 4);
        chk("flush_stall_cycles", {28'd0, stall_cycles}, 4);

        // 20 stalled cycles saturate the 4-bit stall counter.
        drive(1, 0, 32'h0A, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            expect_item(32'h0A, 0, 1);
            step();
        end
        chk("sat_stall_cycles", {28'd0, stall_cycles}, 15);

        // Tie (last grant was lane 2) serves lane 1, then lane 2 waits under backpressure.
        drive(1, 0, 32'h0A, 1, 0, 32'h0B, 1);
        expect_item(32'h0A, 0, 1);
        step();
        out_ready = 1'b0;
        expect_item(32'h0B, 1, 1);
        step();
        chk("pre_rst_grant_count_1", {28'd0, grant_count_1}, 3);

        // Reset mid-stall: served clears, so lane 1 is pending again and wins the tie.
        reset_n = 1'b0;
        #1;
        chk("midrst_stall_cycles", {28'd0, stall_cycles}, 0);
        chk("midrst_grant_count_1", {28'd0, grant_count_1}, 0);
        chk("midrst_out_src", {31'd0, out_src}, 0);
        chk("midrst_out_data", out_data, 32'h0A);
        step();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        expect_item(32'h0A, 0, 1);
        expect_item(32'h0B, 1, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_grant_count_1", {28'd0, grant_count_1}, 1);
        chk("post_rst_grant_count_2", {28'd0, grant_count_2}, 1);
        chk("post_rst_stall_cycles", {28'd0, stall_cycles}, 1);

        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
